// File: rtl/threshold_pkg.sv
// Shared types and helpers for the hysteresis threshold detector.
// Holds the detect FSM state encoding and the saturating fixed-point shift.
package threshold_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_ACTIVE  = 2'd2,
    ST_HOLDOFF = 2'd3
  } state_t;

  localparam int unsigned SAT_MAX_W = 64;

  // Drop the fractional bits, then clamp to all-ones of 'width' if anything is left above it.
  function automatic logic [SAT_MAX_W-1:0] sat_shift(input logic [SAT_MAX_W-1:0] prod,
                                                     input int unsigned frac,
                                                     input int unsigned width);
    logic [SAT_MAX_W-1:0] shifted;
    logic [SAT_MAX_W-1:0] ones;
    shifted = prod >> frac;
    ones    = (width >= SAT_MAX_W) ? '1 : ((SAT_MAX_W'(1) << width) - SAT_MAX_W'(1));
    return ((shifted & ~ones) != '0) ? ones : shifted;
  endfunction

endpackage

// File: rtl/threshold_hyst_detect_if.sv
// Stream bundle for threshold_hyst_detect: signal input i0, reference input i1, detect output o.
// Handshake: a beat moves on a rising clk edge where tvalid & tready are both 1; a source holds
// tdata/tlast/tvalid stable until that edge, and tready may depend combinationally on tvalid.
interface threshold_hyst_detect_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] i0_tdata;
  logic             i0_tlast;
  logic             i0_tvalid;
  logic             i0_tready;
  logic [WIDTH-1:0] i1_tdata;
  logic             i1_tlast;
  logic             i1_tvalid;
  logic             i1_tready;
  logic             o_tdata;
  logic             o_tuser;
  logic             o_tlast;
  logic             o_tvalid;
  logic             o_tready;

  modport master (
    output i0_tdata, i0_tlast, i0_tvalid,
    input  i0_tready,
    output i1_tdata, i1_tlast, i1_tvalid,
    input  i1_tready,
    input  o_tdata, o_tuser, o_tlast, o_tvalid,
    output o_tready
  );

  modport slave (
    input  i0_tdata, i0_tlast, i0_tvalid,
    output i0_tready,
    input  i1_tdata, i1_tlast, i1_tvalid,
    output i1_tready,
    output o_tdata, o_tuser, o_tlast, o_tvalid,
    input  o_tready
  );
endinterface

// File: rtl/threshold_scale_mult.sv
// Scales a reference magnitude by an unsigned fixed-point factor, saturating to WIDTH bits.
// One register stage; the result loads only when ld is high.
module threshold_scale_mult
  import threshold_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SCALE_W   = 16,
  parameter int unsigned FRAC_BITS = 12
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               ld,
  input  logic [WIDTH-1:0]   ref_mag,
  input  logic [SCALE_W-1:0] scale,
  output logic [WIDTH-1:0]   thr
);

  localparam int unsigned PROD_W = WIDTH + SCALE_W;

  logic [PROD_W-1:0] prod;

  assign prod = PROD_W'(ref_mag) * PROD_W'(scale);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      thr <= '0;
    end else if (clear) begin
      thr <= '0;
    end else if (ld) begin
      thr <= WIDTH'(sat_shift(SAT_MAX_W'(prod), FRAC_BITS, WIDTH));
    end
  end

endmodule

// File: rtl/threshold_hyst_detect.sv
// Joins signal and reference streams, scales the reference into on/off thresholds and runs a
// hysteresis detect FSM with minimum-duration entry and post-exit holdoff; two pipeline stages.
module threshold_hyst_detect
  import threshold_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SCALE_W   = 16,
  parameter int unsigned FRAC_BITS = 12,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  threshold_hyst_detect_if.slave bus,
  input  logic [SCALE_W-1:0]    on_scale,
  input  logic [SCALE_W-1:0]    off_scale,
  input  logic [CNT_W-1:0]      min_len,
  input  logic [CNT_W-1:0]      holdoff,
  output logic [31:0]           event_count,
  output state_t                state_dbg
);

  logic             s1_valid;
  logic             s1_ready;
  logic             s2_ready;
  logic             accept;
  logic             xfer;
  logic [WIDTH-1:0] s1_i0;
  logic             s1_last;
  logic [WIDTH-1:0] thr_on;
  logic [WIDTH-1:0] thr_off;

  logic             o_valid_q;
  logic             o_data_q;
  logic             o_user_q;
  logic             o_last_q;

  state_t           state;
  state_t           state_nx;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nx;
  logic [CNT_W:0]   cnt_inc;
  logic [CNT_W-1:0] ml;
  logic             above_on;
  logic             below_off;
  logic             det;
  logic             pulse;
  logic             i1_last_unused;

  assign i1_last_unused = bus.i1_tlast;

  // Join: both streams move together, and never while a flush is in progress.
  assign s2_ready      = ~o_valid_q | bus.o_tready;
  assign s1_ready      = ~s1_valid | s2_ready;
  assign accept        = bus.i0_tvalid & bus.i1_tvalid & s1_ready & ~clear & ~reset;
  assign bus.i0_tready = accept;
  assign bus.i1_tready = accept;
  assign xfer          = s1_valid & s2_ready;

  // Stage 1: sample, frame marker and both scaled thresholds.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_i0    <= '0;
      s1_last  <= 1'b0;
    end else if (clear) begin
      s1_valid <= 1'b0;
      s1_i0    <= '0;
      s1_last  <= 1'b0;
    end else begin
      if (s1_ready) begin
        s1_valid <= accept;
      end
      if (accept) begin
        s1_i0   <= bus.i0_tdata;
        s1_last <= bus.i0_tlast;
      end
    end
  end

  threshold_scale_mult #(
    .WIDTH     (WIDTH),
    .SCALE_W   (SCALE_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_mult_on (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .ld      (accept),
    .ref_mag (bus.i1_tdata),
    .scale   (on_scale),
    .thr     (thr_on)
  );

  threshold_scale_mult #(
    .WIDTH     (WIDTH),
    .SCALE_W   (SCALE_W),
    .FRAC_BITS (FRAC_BITS)
  ) u_mult_off (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .ld      (accept),
    .ref_mag (bus.i1_tdata),
    .scale   (off_scale),
    .thr     (thr_off)
  );

  // Stage 2 compare and detect FSM next-state.
  assign above_on  = s1_i0 > thr_on;
  assign below_off = s1_i0 < thr_off;
  assign ml        = (min_len == '0) ? CNT_W'(1) : min_len;
  assign cnt_inc   = {1'b0, cnt} + (CNT_W+1)'(1);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    det      = 1'b0;
    pulse    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (above_on) begin
          if (ml == CNT_W'(1)) begin
            state_nx = ST_ACTIVE;
            cnt_nx   = '0;
            det      = 1'b1;
            pulse    = 1'b1;
          end else begin
            state_nx = ST_PENDING;
            cnt_nx   = CNT_W'(1);
          end
        end else begin
          cnt_nx = '0;
        end
      end
      ST_PENDING: begin
        if (!above_on) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else if (cnt_inc >= {1'b0, ml}) begin
          state_nx = ST_ACTIVE;
          cnt_nx   = '0;
          det      = 1'b1;
          pulse    = 1'b1;
        end else begin
          cnt_nx = cnt_inc[CNT_W-1:0];
        end
      end
      ST_ACTIVE: begin
        if (below_off) begin
          if (holdoff != '0) begin
            state_nx = ST_HOLDOFF;
            cnt_nx   = CNT_W'(1);
          end else begin
            state_nx = ST_IDLE;
            cnt_nx   = '0;
          end
        end else begin
          det = 1'b1;
        end
      end
      ST_HOLDOFF: begin
        // Samples here are swallowed regardless of level; cnt counts them.
        if (cnt >= holdoff) begin
          state_nx = ST_IDLE;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt_inc[CNT_W-1:0];
        end
      end
      default: begin
        state_nx = ST_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Stage 2 registers: the FSM only moves when a sample actually enters this stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_valid_q   <= 1'b0;
      o_data_q    <= 1'b0;
      o_user_q    <= 1'b0;
      o_last_q    <= 1'b0;
      state       <= ST_IDLE;
      cnt         <= '0;
      event_count <= '0;
    end else if (clear) begin
      o_valid_q   <= 1'b0;
      o_data_q    <= 1'b0;
      o_user_q    <= 1'b0;
      o_last_q    <= 1'b0;
      state       <= ST_IDLE;
      cnt         <= '0;
      event_count <= '0;
    end else begin
      if (s2_ready) begin
        o_valid_q <= s1_valid;
      end
      if (xfer) begin
        o_data_q <= det;
        o_user_q <= pulse;
        o_last_q <= s1_last;
        state    <= state_nx;
        cnt      <= cnt_nx;
        if (pulse && (event_count != '1)) begin
          event_count <= event_count + 32'd1;
        end
      end
    end
  end

  assign bus.o_tvalid = o_valid_q;
  assign bus.o_tdata  = o_data_q;
  assign bus.o_tuser  = o_user_q;
  assign bus.o_tlast  = o_last_q;
  assign state_dbg    = state;

endmodule
